// File: rtl/ext_unit_pipe_pkg.sv
// Mode encodings shared by the extension unit, its interface and the core mux.
package ext_pkg;
    localparam int EXT_MODE_W = 3;

    localparam logic [EXT_MODE_W-1:0] EXT_ZERO   = 3'd0;
    localparam logic [EXT_MODE_W-1:0] EXT_SIGN   = 3'd1;
    localparam logic [EXT_MODE_W-1:0] EXT_UPPER  = 3'd2;
    localparam logic [EXT_MODE_W-1:0] EXT_BYTE_S = 3'd3;
    localparam logic [EXT_MODE_W-1:0] EXT_BYTE_Z = 3'd4;
    localparam logic [EXT_MODE_W-1:0] EXT_HALF_S = 3'd5;
    localparam logic [EXT_MODE_W-1:0] EXT_HALF_Z = 3'd6;
    localparam logic [EXT_MODE_W-1:0] EXT_RSVD   = 3'd7;
endpackage

// File: rtl/ext_unit_pipe_if.sv
// Valid/ready input and output channels of the extension unit.
interface ext_unit_pipe_if
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_W-1:0]       in_data;
    logic [EXT_MODE_W-1:0] in_mode;
    logic [TAG_W-1:0]      in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_data;
    logic [TAG_W-1:0]      out_tag;
    logic                  out_err;

    modport master (
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/ext_unit_pipe_core.sv
// Combinational extension mux: one result per mode, err flags the reserved encoding.
module ext_core
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]       in_data,
    input  logic [EXT_MODE_W-1:0] in_mode,
    output logic [OUT_W-1:0]      result,
    output logic                  err
);
    // Narrow inputs have no full halfword, so half modes fall back to whole-field extension.
    localparam int HW = (IN_W < 16) ? IN_W : 16;

    logic [7:0]    byte_f;
    logic [HW-1:0] half_f;

    assign byte_f = in_data[7:0];
    assign half_f = in_data[HW-1:0];

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (in_mode)
            EXT_ZERO:   result = OUT_W'(in_data);
            EXT_SIGN:   result = OUT_W'($signed(in_data));
            EXT_UPPER:  result = OUT_W'(in_data) << (OUT_W - IN_W);
            EXT_BYTE_S: result = OUT_W'($signed(byte_f));
            EXT_BYTE_Z: result = OUT_W'(byte_f);
            EXT_HALF_S: result = OUT_W'($signed(half_f));
            EXT_HALF_Z: result = OUT_W'(half_f);
            default:    err    = 1'b1;
        endcase
    end
endmodule

// File: rtl/ext_unit_pipe.sv
// Pipelined immediate/load-data extender with registered output and transfer counter.
// EXT_UNIT_SKID_EN: adds a one-entry skid so in_ready is fully registered.
module ext_unit_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ext_unit_pipe_if.slave   bus,
    output logic [CNT_W-1:0] xfer_cnt
);
    logic [OUT_W-1:0] core_res;
    logic             core_err;

    ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .in_data (bus.in_data),
        .in_mode (bus.in_mode),
        .result  (core_res),
        .err     (core_err)
    );

    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_err_q;
    logic             accept;
    logic             emit;

    assign accept        = bus.in_valid && bus.in_ready;
    assign emit          = out_valid_q && bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_err   = out_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) xfer_cnt <= '0;
        else if (emit) xfer_cnt <= xfer_cnt + CNT_W'(1);
    end

`ifdef EXT_UNIT_SKID_EN
    logic             skid_valid;
    logic [OUT_W-1:0] skid_data;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_err;
    logic             skid_valid_nxt;
    logic             rdy_q;

    // Skid can only fill while out is held; it drains on the next emit.
    always_comb begin
        skid_valid_nxt = skid_valid;
        if (skid_valid && emit)                      skid_valid_nxt = 1'b0;
        else if (!skid_valid && accept && out_valid_q && !emit) skid_valid_nxt = 1'b1;
    end

    assign bus.in_ready = rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_tag    <= '0;
            skid_err    <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            rdy_q      <= !skid_valid_nxt;
            skid_valid <= skid_valid_nxt;
            if (emit) begin
                if (skid_valid) begin
                    out_data_q <= skid_data;
                    out_tag_q  <= skid_tag;
                    out_err_q  <= skid_err;
                end else if (accept) begin
                    out_data_q <= core_res;
                    out_tag_q  <= bus.in_tag;
                    out_err_q  <= core_err;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (accept) begin
                if (!out_valid_q) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= core_res;
                    out_tag_q   <= bus.in_tag;
                    out_err_q   <= core_err;
                end else begin
                    skid_data <= core_res;
                    skid_tag  <= bus.in_tag;
                    skid_err  <= core_err;
                end
            end
        end
    end
`else
    logic en_q;

    // en_q keeps in_ready low until the first edge after reset release.
    assign bus.in_ready = en_q && (!out_valid_q || bus.out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            en_q <= 1'b1;
            if (bus.in_ready) begin
                out_valid_q <= accept;
                if (accept) begin
                    out_data_q <= core_res;
                    out_tag_q  <= bus.in_tag;
                    out_err_q  <= core_err;
                end
            end
        end
    end
`endif
endmodule

// File: doc/ext_unit_pipe.md
Name: ext_unit_pipe

Overview:
- Parametrised, pipelined immediate/load-data extension unit; successor to the combinational 16->32 sign extender.
- Supports zero, sign, upper-placement (LUI-style), byte and halfword extension modes, plus a tag pass-through.
- Sits between decode/memory-read and the ALU/writeback mux.
- Uses a valid/ready handshake with a registered output stage so it can be dropped into the pipelined datapath.

Parameters:
- IN_W, 16, input field width; legal range 8..OUT_W.
- OUT_W, 32, output width; must be >= IN_W.
- TAG_W, 5, width of the sideband tag carried with each item (e.g. destination register).
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input item present.
- in_ready  out  1  unit can accept an item this cycle.
- in_data  in  IN_W  field to extend.
- in_mode  in  3  extension mode; encodings in ext_pkg.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output item present.
- out_ready  in  1  consumer accepts the item.
- out_data  out  OUT_W  extended result.
- out_tag  out  TAG_W  tag of the output item.
- out_err  out  1  item used a reserved mode.
- xfer_cnt  out  CNT_W  count of completed output handshakes.

Behaviour:
- Handshakes:
  - Accept occurs when in_valid && in_ready. Emit occurs when out_valid && out_ready.
  - out_data, out_tag and out_err hold stable while out_valid && !out_ready.
- Latency: 1 cycle from accept to out_valid, with no bubble when out_ready stays high. Throughput is 1 item/cycle.
- Modes (result computed combinationally from the inputs, then registered):
  - 0 ZERO: {0, in_data}.
  - 1 SIGN: replicate in_data[IN_W-1] into the upper bits.
  - 2 UPPER: in_data placed in out[OUT_W-1 -: IN_W]; lower bits 0.
  - 3 BYTE_S: sign-extend in_data[7:0].
  - 4 BYTE_Z: zero-extend in_data[7:0].
  - 5 HALF_S: sign-extend in_data[15:0]. If IN_W < 16, behaves as SIGN.
  - 6 HALF_Z: zero-extend in_data[15:0]. If IN_W < 16, behaves as ZERO.
  - 7 reserved: out_data = 0, out_err = 1. For every other mode out_err = 0.
- If OUT_W == IN_W, modes 0/1/2 pass in_data unchanged.
- Reset (async, Rst_n low):
  - out_valid = 0, out_data = 0, out_tag = 0, out_err = 0, xfer_cnt = 0, skid emptied.
  - in_ready = 0 while Rst_n is low, then 1 on the first cycle after deassertion.
  - Reset mid-transfer discards all held items; no partial item is emitted.
- xfer_cnt increments by 1 per emit and wraps from 2^CNT_W-1 to 0.
- Output stage with skid (see Optional Feature):
  - Holds an out register and a one-entry skid register.
  - in_ready = !skid_valid, registered (no combinational path from out_ready).
  - Accept while the out register is empty or being emitted: item loads into out.
  - Accept while out is held (out_valid && !out_ready): item loads into skid.
  - Emit while skid is full: skid moves to out in the same cycle and skid empties.
  - Simultaneous accept + emit with skid empty: new item goes to out.
  - Items are never reordered, dropped or duplicated.

Optional Feature:
- Macro: EXT_UNIT_SKID_EN.
- Defined: two-entry output stage as described above. in_ready has no combinational dependence on out_ready.
- Undefined:
  - Single output register; in_ready = !out_valid || out_ready (combinational).
  - Same 1-cycle latency and full throughput while out_ready = 1. Reset values unchanged.

Decomposition:
- Package ext_pkg:
  - localparams EXT_ZERO=0, EXT_SIGN=1, EXT_UPPER=2, EXT_BYTE_S=3, EXT_BYTE_Z=4, EXT_HALF_S=5, EXT_HALF_Z=6, EXT_RSVD=7.
  - Mode width constant EXT_MODE_W=3.
- One sub-module, ext_core: purely combinational mode mux (in_data, in_mode -> result, err). The top level holds the handshake, skid and counter.

Test Plan:
- IN_W=16/OUT_W=32, out_ready=1, send in_data=0x8001 in SIGN, ZERO and UPPER modes back-to-back -> out_data 0xFFFF8001, 0x00008001, 0x80010000 on consecutive cycles, each 1 cycle after accept; xfer_cnt=3.
- in_data=0x00F0 in BYTE_S then BYTE_Z; 0x7FFF in HALF_S -> 0xFFFFFFF0, 0x000000F0, 0x00007FFF.
- Mode 7 with in_data=0xABCD -> out_data=0, out_err=1; following SIGN item -> out_err=0.
- Hold out_ready=0 for 4 cycles while offering 3 items tagged 1,2,3:
  - SKID_EN: accepts 2, in_ready drops, out_data holds item 1.
  - Without SKID_EN: accepts 1.
  - Release out_ready -> tags emitted 1,2,3 in order, no loss.
- Pulse Rst_n low asynchronously (mid-cycle) with out_valid=1 and skid full -> out_valid, out_err and xfer_cnt go to 0 immediately; no stale item emitted after release.
- CNT_W=4: complete 17 transfers -> xfer_cnt wraps to 1.
